keypad_scan: RTL
================

Name: keypad_scan

Overview:
- 4x4 matrix keypad scanner: the input-side counterpart of the 7-segment display driver.
- Drives the keypad columns with an active-low rotating one-hot pattern, senses the rows, debounces press and release, and outputs one key code per press.
- Key-code consumers use a level-valid/ack handshake.
- Also emits a one-cycle mode_pulse that feeds the clock's mode input.

Parameters:
- DEBOUNCE_MS, 20, consecutive stable 1 ms cycles required for both press and release (legal 2..255).
- SETTLE, 3, cycles each column is held in SCAN before the rows are sampled (legal 3..7).
- MODE_KEY, 4'hA, key code that also produces mode_pulse.

Ports:
- clk_1KHZ  input  1  scan/debounce clock, 1 kHz.
- rst_n  input  1  reset, asynchronous, active-low.
- key_row  input  4  keypad rows, active-low, external pull-ups, asynchronous to clk_1KHZ.
- key_col  output  4  column drive, active-low one-hot.
- key_code  output  4  code of the last accepted key, row*4+col.
- key_valid  output  1  high while key_code is unconsumed.
- key_ack  input  1  consumer acknowledge, sampled on clk_1KHZ.
- mode_pulse  output  1  one-cycle pulse when MODE_KEY is accepted.
- overrun  output  1  sticky: a key was dropped because key_valid was still pending.

Behaviour:
- Reset (async assert, sync release) sets:
  - key_col=4'b1110, key_code=0, key_valid=0, mode_pulse=0, overrun=0;
  - state=SCAN, dwell and debounce counters=0.
- Row input: key_row passes through a 2-FF synchronizer (row_s). All decisions use row_s only.
- State SCAN:
  - key_col holds for SETTLE cycles, then rotates left: 1110→1101→1011→0111→1110.
  - On the last dwell cycle, if any row_s bit is 0:
    - capture row index (lowest-index low row wins) and column index;
    - freeze key_col, clear the debounce counter, go to PRESS_DB.
  - Otherwise advance to the next column.
- State PRESS_DB:
  - Each cycle the captured row_s bit is 0, the counter increments.
  - If that bit is seen 1: clear the counter, return to SCAN, advance to the next column.
  - When the counter reaches DEBOUNCE_MS-1 with the row still 0: accept the key and go to HELD.
- Key accept, same edge:
  - If key_valid=0, or key_ack=1 this cycle: key_code<=row*4+col, key_valid<=1.
  - Otherwise: key_code unchanged, overrun<=1.
  - mode_pulse<=1 for exactly one cycle if the captured code==MODE_KEY, even when the key is dropped by overrun.
- State HELD: wait until the captured row_s bit is 1, then clear the counter and go to REL_DB. Other keys are ignored; no repeat codes.
- State REL_DB:
  - Count consecutive cycles with the captured row_s bit = 1.
  - A 0 returns to HELD with the counter cleared.
  - At DEBOUNCE_MS-1: go to SCAN, advance the column, restart dwell.
- Handshake:
  - key_valid clears on the edge after key_ack is sampled high.
  - key_ack also clears overrun.
  - key_ack while key_valid=0 is ignored.
  - Simultaneous ack and accept: the new key wins, key_valid stays 1, overrun is not set.
- Widths: counters are 8 bits. The 2-bit row/col indices are concatenated {row,col} to form key_code.
- key_col is registered and glitch-free: exactly one bit low at all times after reset.
- Reset mid-debounce or mid-held: immediate return to reset values. A held key is rescanned and re-accepted after a full debounce.
- Minimum press-to-valid latency: 2 sync cycles + up to 4*SETTLE scan cycles + DEBOUNCE_MS cycles.

Decomposition:
- Shared package clock_pkg:
  - state enum {SCAN, PRESS_DB, HELD, REL_DB};
  - column reset constant 4'b1110;
  - key code constants: KEY_MODE=4'hA, digits 0–9 = codes 0–9.
- One sub-module: key_debounce_cnt. Holds the 8-bit saturating counter with clear/enable and a done flag at DEBOUNCE_MS-1; it is shared by PRESS_DB and REL_DB.
- The synchronizer is inline.

Test Plan:
- No key pressed, 40 cycles after reset: key_col cycles 1110,1101,1011,0111, each held 3 cycles; key_valid=0 throughout.
- Row 1 held low while key_col=1011 (col 2) for 30 ms, no ack:
  - key_valid rises with key_code=4'h6, about 20 cycles after detection;
  - one press gives one code; after release plus 20 stable cycles, scanning resumes.
- Bounce: row 0 toggles every 3 ms for 15 ms, then stable low: no accept during bouncing; a single accept 20 cycles after the last bounce.
- Press key 5, no ack, then press key 2:
  - key_code stays 4'h5 and overrun=1;
  - key_ack pulse clears both key_valid and overrun on the next edge.
- Press MODE_KEY (row 2, col 2): key_code=4'hA, and mode_pulse is high for exactly one cycle on the accept edge.
- Reset asserted during PRESS_DB at count 10:
  - outputs return to reset values asynchronously;
  - after release, with the key still held, a full debounce is needed before key_valid rises.

Source files
------------

// File: rtl/clock_pkg.sv
// clock_pkg: definitions shared by the clock/display/keypad slice.
// Holds the keypad scanner state encoding, the column drive reset pattern,
// the key code constants and two small decode helpers.
package clock_pkg;

  typedef enum logic [1:0] {
    SCAN,
    PRESS_DB,
    HELD,
    REL_DB
  } scan_state_e;

  localparam logic [3:0] COL_RESET = 4'b1110;

  localparam logic [3:0] KEY_0    = 4'h0;
  localparam logic [3:0] KEY_1    = 4'h1;
  localparam logic [3:0] KEY_2    = 4'h2;
  localparam logic [3:0] KEY_3    = 4'h3;
  localparam logic [3:0] KEY_4    = 4'h4;
  localparam logic [3:0] KEY_5    = 4'h5;
  localparam logic [3:0] KEY_6    = 4'h6;
  localparam logic [3:0] KEY_7    = 4'h7;
  localparam logic [3:0] KEY_8    = 4'h8;
  localparam logic [3:0] KEY_9    = 4'h9;
  localparam logic [3:0] KEY_MODE = 4'hA;

  // Index of the lowest active-low row; when several rows are low the
  // lowest index wins.
  function automatic logic [1:0] first_low_row(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Index of the column currently driven low by a one-hot-low pattern.
  function automatic logic [1:0] col_index(input logic [3:0] cols);
    logic [1:0] idx;
    case (cols)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// keypad_scan_if: key code handshake between the keypad scanner and its
// consumer.
//   key_code   4  code of the last accepted key ({row,col})
//   key_valid  1  level valid, high while key_code is unconsumed
//   key_ack    1  consumer acknowledge
//   mode_pulse 1  one-cycle pulse when the mode key is accepted
//   overrun    1  sticky flag: a key was dropped while key_valid was pending
// The master modport is the scanner, the slave modport is the consumer.
interface keypad_scan_if;

  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       mode_pulse;
  logic       overrun;

  modport master (
    output key_code,
    output key_valid,
    output mode_pulse,
    output overrun,
    input  key_ack
  );

  modport slave (
    input  key_code,
    input  key_valid,
    input  mode_pulse,
    input  overrun,
    output key_ack
  );

endinterface

// File: rtl/key_debounce_cnt.sv
// key_debounce_cnt: 8-bit saturating stability counter shared by the press
// and release debounce phases of the keypad scanner.
//   clk_1KHZ  in   1 ms tick clock
//   rst_n     in   asynchronous active-low reset
//   clr       in   synchronous clear (has priority over en)
//   en        in   count one more stable cycle
//   done      out  counter has reached DEBOUNCE_MS-1
module key_debounce_cnt #(
  parameter int unsigned DEBOUNCE_MS = 20
) (
  input  logic clk_1KHZ,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic done
);

  logic [7:0] count;

  // Saturate at 255 so a long enable can never wrap back into range.
  always_ff @(posedge clk_1KHZ or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (clr) begin
      count <= 8'd0;
    end else if (en && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

  assign done = (count == 8'(DEBOUNCE_MS - 1));

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner.
// Rotates an active-low one-hot pattern over the columns, samples the
// synchronized rows, debounces press and release and hands one key code per
// press to the consumer over a level-valid/ack handshake.
//   clk_1KHZ  in   1 kHz scan/debounce clock
//   rst_n     in   asynchronous active-low reset (released synchronously)
//   key_row   in   4 keypad rows, active-low, asynchronous
//   key_col   out  4 column drive, active-low one-hot, registered
//   key_bus   master side of keypad_scan_if (code/valid/ack/mode/overrun)
module keypad_scan
  import clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned SETTLE      = 3,
  parameter logic [3:0]  MODE_KEY    = KEY_MODE
) (
  input  logic          clk_1KHZ,
  input  logic          rst_n,
  input  logic [3:0]    key_row,
  output logic [3:0]    key_col,
  keypad_scan_if.master key_bus
);

  scan_state_e state, state_next;

  logic       rst_meta, rst_sync_n;
  logic [3:0] row_meta, row_s;
  logic [7:0] dwell;
  logic [3:0] col_q;
  logic [1:0] row_idx, col_idx;
  logic [3:0] code_q;
  logic       valid_q, mode_q, overrun_q;

  logic       dwell_last, any_low, row_bit;
  logic       cnt_clr, cnt_en, cnt_done;
  logic       col_advance, capture, accept;
  logic [3:0] captured_code;

  // Reset asserts immediately but releases on a clock edge, so no flop sees
  // the release close to its active edge.
  always_ff @(posedge clk_1KHZ or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta   <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      rst_meta   <= 1'b1;
      rst_sync_n <= rst_meta;
    end
  end

  // Two-stage synchronizer; the rows idle high through the pull-ups.
  always_ff @(posedge clk_1KHZ or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      row_meta <= 4'hF;
      row_s    <= 4'hF;
    end else begin
      row_meta <= key_row;
      row_s    <= row_meta;
    end
  end

  assign dwell_last    = (dwell == 8'(SETTLE - 1));
  assign any_low       = (row_s != 4'hF);
  assign row_bit       = row_s[row_idx];
  assign captured_code = {row_idx, col_idx};

  key_debounce_cnt #(
    .DEBOUNCE_MS(DEBOUNCE_MS)
  ) u_debounce (
    .clk_1KHZ(clk_1KHZ),
    .rst_n   (rst_sync_n),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .done    (cnt_done)
  );

  always_ff @(posedge clk_1KHZ or negedge rst_sync_n) begin
    if (!rst_sync_n) state <= SCAN;
    else             state <= state_next;
  end

  // The captured row bit is the only input looked at once a key has been
  // found; any other key pressed meanwhile is ignored.
  always_comb begin
    state_next  = state;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    col_advance = 1'b0;
    capture     = 1'b0;
    accept      = 1'b0;
    case (state)
      SCAN: begin
        if (dwell_last) begin
          if (any_low) begin
            capture    = 1'b1;
            cnt_clr    = 1'b1;
            state_next = PRESS_DB;
          end else begin
            col_advance = 1'b1;
          end
        end
      end
      PRESS_DB: begin
        if (row_bit) begin
          cnt_clr     = 1'b1;
          col_advance = 1'b1;
          state_next  = SCAN;
        end else if (cnt_done) begin
          accept     = 1'b1;
          state_next = HELD;
        end else begin
          cnt_en = 1'b1;
        end
      end
      HELD: begin
        if (row_bit) begin
          cnt_clr    = 1'b1;
          state_next = REL_DB;
        end
      end
      REL_DB: begin
        if (!row_bit) begin
          cnt_clr    = 1'b1;
          state_next = HELD;
        end else if (cnt_done) begin
          cnt_clr     = 1'b1;
          col_advance = 1'b1;
          state_next  = SCAN;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: begin
        state_next = SCAN;
      end
    endcase
  end

  // Dwell only runs in SCAN; leaving the scan phase parks it at zero so the
  // next column always gets its full settle time.
  always_ff @(posedge clk_1KHZ or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      dwell <= 8'd0;
    end else if ((state != SCAN) || dwell_last) begin
      dwell <= 8'd0;
    end else begin
      dwell <= dwell + 8'd1;
    end
  end

  // Rotating the register itself keeps exactly one column low at all times.
  always_ff @(posedge clk_1KHZ or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      col_q <= COL_RESET;
    end else if (col_advance) begin
      col_q <= {col_q[2:0], col_q[3]};
    end
  end

  always_ff @(posedge clk_1KHZ or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      row_idx <= 2'd0;
      col_idx <= 2'd0;
    end else if (capture) begin
      row_idx <= first_low_row(row_s);
      col_idx <= col_index(col_q);
    end
  end

  // An ack on the accept edge frees the slot, so the new key wins and no
  // overrun is flagged. mode_pulse fires even for a dropped key.
  always_ff @(posedge clk_1KHZ or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      code_q    <= 4'd0;
      valid_q   <= 1'b0;
      mode_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      mode_q <= accept && (captured_code == MODE_KEY);
      if (accept && (!valid_q || key_bus.key_ack)) begin
        code_q  <= captured_code;
        valid_q <= 1'b1;
      end else if (accept) begin
        overrun_q <= 1'b1;
      end else if (valid_q && key_bus.key_ack) begin
        valid_q <= 1'b0;
      end
      if (valid_q && key_bus.key_ack) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign key_col            = col_q;
  assign key_bus.key_code   = code_q;
  assign key_bus.key_valid  = valid_q;
  assign key_bus.mode_pulse = mode_q;
  assign key_bus.overrun    = overrun_q;

endmodule
